// File: rtl/user_input_events_pkg.sv
// user_input_events_pkg: key indices, event encoding and arbitration helpers
package user_input_events_pkg;

   localparam int NUM_KEYS     = 5;
   localparam int KEY_LEFT     = 0;
   localparam int KEY_RIGHT    = 1;
   localparam int KEY_DOWN     = 2;
   localparam int KEY_ROTATE   = 3;
   localparam int KEY_NEW_GAME = 4;

   localparam logic [NUM_KEYS-1:0] KEY_ONE = 'd1;

   typedef enum logic [2:0] {
      EV_NONE     = 3'd0,
      EV_LEFT     = 3'd1,
      EV_RIGHT    = 3'd2,
      EV_DOWN     = 3'd3,
      EV_ROTATE   = 3'd4,
      EV_NEW_GAME = 3'd5
   } user_event_t;

   // One-hot grant of the highest-priority pending key: new game > rotate > left > right > down
   function automatic logic [NUM_KEYS-1:0] grant_of(input logic [NUM_KEYS-1:0] p);
      return p[KEY_NEW_GAME] ? KEY_ONE << KEY_NEW_GAME :
             p[KEY_ROTATE]   ? KEY_ONE << KEY_ROTATE   :
             p[KEY_LEFT]     ? KEY_ONE << KEY_LEFT     :
             p[KEY_RIGHT]    ? KEY_ONE << KEY_RIGHT    :
             p[KEY_DOWN]     ? KEY_ONE << KEY_DOWN     : '0;
   endfunction

   // Event code for a one-hot key grant
   function automatic user_event_t event_of(input logic [NUM_KEYS-1:0] g);
      return g[KEY_NEW_GAME] ? EV_NEW_GAME :
             g[KEY_ROTATE]   ? EV_ROTATE   :
             g[KEY_LEFT]     ? EV_LEFT     :
             g[KEY_RIGHT]    ? EV_RIGHT    :
             g[KEY_DOWN]     ? EV_DOWN     : EV_NONE;
   endfunction

endpackage

// File: rtl/user_input_events_fifo.sv
// user_input_events_fifo: show-ahead FIFO of user_event_t entries, accepts a push into a full FIFO when popped the same cycle
module user_input_events_fifo
   import user_input_events_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        wr_en_i,
   input  user_event_t wr_data_i,
   input  logic        rd_req_i,
   output user_event_t rd_data_o,
   output logic        ready_o,
   output logic        wr_ok_o
);

   localparam int AW = $clog2(DEPTH);

   user_event_t   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   assign ready_o   = r_count != '0;
   assign w_pop     = rd_req_i && ready_o;
   assign wr_ok_o   = (r_count != (AW+1)'(DEPTH)) || w_pop;
   assign w_push    = wr_en_i && wr_ok_o;
   assign rd_data_o = r_mem[r_rd_ptr];

   // Storage, wrapping pointers and occupancy; a read request on an empty FIFO changes nothing
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= EV_NONE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_mem[r_wr_ptr] <= wr_data_i;
         r_wr_ptr <= r_wr_ptr + AW'(w_push);
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end

endmodule

// File: rtl/user_input_events.sv
// user_input_events: synchronize, debounce and auto-repeat player keys into a prioritized event FIFO
module user_input_events
   import user_input_events_pkg::*;
#(
   parameter int DEBOUNCE_CYC      = 500000,
   parameter int REPEAT_DELAY_CYC  = 15000000,
   parameter int REPEAT_PERIOD_CYC = 4000000,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [NUM_KEYS-1:0] key_i,
   output user_event_t         user_event_o,
   output logic                user_event_ready_o,
   input  logic                user_event_rd_req_i,
   output logic                overflow_o
);

   localparam int DW = $clog2(DEBOUNCE_CYC);
   localparam int RW = $clog2((REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC) + 1);

   logic [NUM_KEYS-1:0] r_s1;
   logic [NUM_KEYS-1:0] r_s2;
   logic [1:0]          r_live;
   logic [NUM_KEYS-1:0] r_pending;
   logic                r_overflow;
   logic [NUM_KEYS-1:0] w_set;
   logic [NUM_KEYS-1:0] w_grant;
   logic [NUM_KEYS-1:0] w_clr;
   logic                w_wr_ok;
   logic                w_wr;

   // Two-flop synchronizers; r_live marks when r_s2 holds real samples after reset
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_live <= '0;
      end else begin
         r_s1   <= key_i;
         r_s2   <= r_s1;
         r_live <= {r_live[0], 1'b1};
      end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      localparam bit REP = (k <= KEY_DOWN);
      logic [DW-1:0] r_cnt;
      logic [RW-1:0] r_rep;
      logic          r_db;
      logic          r_db_q;
      logic          r_arm;
      logic          w_diff;
      logic          w_rise;
      logic          w_fire;
      assign w_diff   = r_s2[k] ^ r_db;
      assign w_rise   = r_db & ~r_db_q;
      assign w_fire   = REP && r_db && r_db_q && (r_rep == '0);
      assign w_set[k] = r_arm & (w_rise | w_fire);
      // Debounce, repeat down-counter, and arming: a key must be seen released after reset before it may raise events
      always_ff @(posedge clk_i or negedge rst_n_i)
         if (!rst_n_i) begin
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
            r_rep  <= '0;
            r_arm  <= 1'b0;
         end else begin
            r_cnt  <= (w_diff && r_cnt != DW'(DEBOUNCE_CYC-1)) ? r_cnt + 1'b1 : '0;
            r_db   <= (w_diff && r_cnt == DW'(DEBOUNCE_CYC-1)) ? ~r_db : r_db;
            r_db_q <= r_db;
            r_rep  <= !r_db         ? '0 :
                      w_rise        ? RW'(REPEAT_DELAY_CYC-1) :
                      r_rep == '0   ? RW'(REPEAT_PERIOD_CYC-1) : r_rep - 1'b1;
            r_arm  <= r_arm | (r_live[1] & ~r_s2[k]);
         end
   end

   assign w_grant = grant_of(r_pending);
   assign w_wr    = (|r_pending) && w_wr_ok;
   assign w_clr   = w_wr ? w_grant : '0;

   // Pending bits: a new request wins over a same-cycle clear; a request on a still-pending key is lost
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_pending  <= w_set | (r_pending & ~w_clr);
         r_overflow <= r_overflow | (|(w_set & r_pending & ~w_clr));
      end

   assign overflow_o = r_overflow;

   user_input_events_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_en_i   (w_wr),
      .wr_data_i (event_of(w_grant)),
      .rd_req_i  (user_event_rd_req_i),
      .rd_data_o (user_event_o),
      .ready_o   (user_event_ready_o),
      .wr_ok_o   (w_wr_ok)
   );

endmodule

// File: tb/tb_user_input_events.sv
// tb_user_input_events: directed scenarios with an expected-event scoreboard for user_input_events
module tb_user_input_events;
   import user_input_events_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  key = '0;
   logic        rd_req = 1'b0;
   user_event_t ev;
   logic        ready;
   logic        overflow;
   int          n_chk = 0;
   int          n_err = 0;
   user_event_t q[$];
   user_event_t evs[5] = '{EV_LEFT, EV_RIGHT, EV_DOWN, EV_ROTATE, EV_NEW_GAME};

   always #5 clk = ~clk;

   user_input_events #(
      .DEBOUNCE_CYC(4),
      .REPEAT_DELAY_CYC(20),
      .REPEAT_PERIOD_CYC(8),
      .FIFO_DEPTH(4)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .key_i(key),
      .user_event_o(ev),
      .user_event_ready_o(ready),
      .user_event_rd_req_i(rd_req),
      .overflow_o(overflow)
   );

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_n(input string tag, input int n);
      user_event_t e;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_ready"}, 32'(ready), 32'd1);
         e = EV_NONE;
         if (q.size() != 0) e = q.pop_front();
         chk(tag, 32'(ev), 32'(e));
         rd_req = 1'b1;
         step();
      end
      rd_req = 1'b0;
   endtask

   task automatic wait_ready(input string tag, input int budget);
      int c = 0;
      while (!ready && c < budget) begin
         step();
         c++;
      end
      chk({tag, "_timeout"}, 32'(ready), 32'd1);
   endtask

   initial begin
      step(3);
      rst_n = 1'b1;
      step(5);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_head", 32'(ev), 32'(EV_NONE));
      // left press: ready exactly at cycle 8, single entry
      key[KEY_LEFT] = 1'b1;
      q.push_back(EV_LEFT);
      step(7);
      chk("t1_ready_c7", 32'(ready), 32'd0);
      step();
      chk("t1_ready_c8", 32'(ready), 32'd1);
      step(2);
      key = '0;
      pop_n("t1_head", 1);
      chk("t1_single", 32'(ready), 32'd0);
      step(30);
      // 3-cycle glitch is filtered
      key[KEY_ROTATE] = 1'b1;
      step(3);
      key = '0;
      step(15);
      chk("t2_glitch", 32'(ready), 32'd0);
      // down held: events at 8, 28, 36, none after release
      key[KEY_DOWN] = 1'b1;
      repeat (3) q.push_back(EV_DOWN);
      step(7);
      chk("t3_c7", 32'(ready), 32'd0);
      step();
      pop_n("t3_ev0", 1);
      chk("t3_c9", 32'(ready), 32'd0);
      step(18);
      chk("t3_c27", 32'(ready), 32'd0);
      step();
      pop_n("t3_ev1", 1);
      step(6);
      chk("t3_c35", 32'(ready), 32'd0);
      key = '0;
      step();
      pop_n("t3_ev2", 1);
      step(30);
      chk("t3_no_more", 32'(ready), 32'd0);
      // simultaneous rotate + new game: priority order
      key[KEY_ROTATE] = 1'b1;
      key[KEY_NEW_GAME] = 1'b1;
      q.push_back(EV_NEW_GAME);
      q.push_back(EV_ROTATE);
      step(7);
      chk("t4_c7", 32'(ready), 32'd0);
      step();
      pop_n("t4_first", 1);
      pop_n("t4_second", 1);
      chk("t4_empty", 32'(ready), 32'd0);
      key = '0;
      step(30);
      // five presses into a 4-deep FIFO; fifth enters on the pop cycle
      for (int i = 0; i < 5; i++) begin
         key = 5'b1 << i;
         q.push_back(evs[i]);
         step(8);
         key = '0;
         step(4);
      end
      step(10);
      chk("t5_overflow", 32'(overflow), 32'd0);
      pop_n("t5_pop", 1);
      pop_n("t5_drain", 4);
      chk("t5_empty", 32'(ready), 32'd0);
      // reads while empty change nothing
      rd_req = 1'b1;
      step(3);
      rd_req = 1'b0;
      chk("t6_empty_rd", 32'(ready), 32'd0);
      key[KEY_ROTATE] = 1'b1;
      q.push_back(EV_ROTATE);
      wait_ready("t6", 20);
      key = '0;
      pop_n("t6_after", 1);
      chk("t6_one", 32'(ready), 32'd0);
      step(20);
      // hold down until FIFO full and a repeat is lost, then reset mid-fill
      key[KEY_DOWN] = 1'b1;
      step(62);
      chk("t7_full", 32'(ready), 32'd1);
      chk("t7_overflow", 32'(overflow), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t7_rst_ready", 32'(ready), 32'd0);
      chk("t7_rst_overflow", 32'(overflow), 32'd0);
      chk("t7_rst_head", 32'(ev), 32'(EV_NONE));
      step(3);
      rst_n = 1'b1;
      step(60);
      chk("t7_held_no_ev", 32'(ready), 32'd0);
      chk("t7_held_overflow", 32'(overflow), 32'd0);
      key = '0;
      step(12);
      key[KEY_DOWN] = 1'b1;
      q.push_back(EV_DOWN);
      wait_ready("t7_repress", 20);
      pop_n("t7_repress_ev", 1);
      key = '0;
      chk("t7_final_empty", 32'(ready), 32'd0);
      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
